// File: rtl/proc_ctrl_fsm.sv
// proc_ctrl_fsm: control unit for an 8-register, 8-bit bus processor.
// Fetches an instruction word from din into ir. Then sequences
// mv / mvi / add / sub by driving the register enables, the bus select,
// the A/G enables, add_sub and the memory-advance strobe.
// Optional feature macro: PROC_CTRL_PERF_EN adds an instr_cnt output that
// counts completed instructions and wraps at 2^CNT_W.
// Outputs are decoded combinationally from the state and ir, so an
// asynchronous reset forces every output to its default in the same cycle.
module proc_ctrl_fsm #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [DATA_W-1:0] din,
  output logic [7:0]        ir,
  output logic [7:0]        r_in,
  output logic [3:0]        bus_sel,
  output logic              a_in,
  output logic              g_in,
  output logic              add_sub,
  output logic              mem_adv,
  output logic              busy,
  output logic              done
`ifdef PROC_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]  instr_cnt
`endif
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_T1    = 2'd1,
    S_T2    = 2'd2,
    S_T3    = 2'd3
  } state_t;

  // Bus source codes driven onto bus_sel
  localparam logic [3:0] BUS_DIN  = 4'd8;
  localparam logic [3:0] BUS_G    = 4'd9;
  localparam logic [3:0] BUS_NONE = 4'd15;

  // Opcode field values (ir[7:6])
  localparam logic [1:0] OP_MV  = 2'b00;
  localparam logic [1:0] OP_MVI = 2'b01;

  state_t     state_reg;
  logic [7:0] ir_reg;

  logic [1:0] op;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       r_wr;    // write Rx this cycle; expanded to one-hot r_in below

  assign op = ir_reg[7:6];
  assign rx = ir_reg[5:3];
  assign ry = ir_reg[2:0];

  // Only din[7:0] carries the instruction; wider words just pass to the bus.
  generate
    if (DATA_W > 8) begin : g_din_hi
      logic unused_din_hi;
      assign unused_din_hi = ^din[DATA_W-1:8];
    end
  endgenerate

  // State sequencing and instruction capture; run only matters in S_FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_FETCH;
      ir_reg    <= 8'h00;
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (run) begin
            ir_reg    <= din[7:0];
            state_reg <= S_T1;
          end
        end
        S_T1: begin
          // mv/mvi finish in T1; add/sub continue through T2 and T3
          if (op[1]) begin
            state_reg <= S_T2;
          end else begin
            state_reg <= S_FETCH;
          end
        end
        S_T2:    state_reg <= S_T3;
        S_T3:    state_reg <= S_FETCH;
        default: state_reg <= S_FETCH;
      endcase
    end
  end

  // Control decode from the current step and the held instruction.
  always_comb begin
    bus_sel = BUS_NONE;
    r_wr    = 1'b0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    mem_adv = 1'b0;
    done    = 1'b0;
    case (state_reg)
      S_FETCH: begin
        // The fetch itself consumes a memory word, so advance the address.
        mem_adv = run;
      end
      S_T1: begin
        if (op == OP_MV) begin
          bus_sel = {1'b0, ry};
          r_wr    = 1'b1;
          done    = 1'b1;
        end else if (op == OP_MVI) begin
          // Immediate word is on din now; step past it for the next fetch.
          bus_sel = BUS_DIN;
          r_wr    = 1'b1;
          mem_adv = 1'b1;
          done    = 1'b1;
        end else begin
          bus_sel = {1'b0, rx};
          a_in    = 1'b1;
        end
      end
      S_T2: begin
        bus_sel = {1'b0, ry};
        g_in    = 1'b1;
      end
      S_T3: begin
        bus_sel = BUS_G;
        r_wr    = 1'b1;
        done    = 1'b1;
      end
      default: begin
        bus_sel = BUS_NONE;
      end
    endcase
  end

  // One-hot register write enable: R0..R7 all decoded, R7 included.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_r_in
      assign r_in[gi] = r_wr && (rx == 3'(gi));
    end
  endgenerate

  // add_sub simply follows op[0]; it is only acted on while g_in is high.
  assign add_sub = ir_reg[6];
  assign busy    = (state_reg != S_FETCH);
  assign ir      = ir_reg;

`ifdef PROC_CTRL_PERF_EN
  logic [CNT_W-1:0] cnt_reg;

  // Completed-instruction counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (done) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign instr_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// tb_proc_ctrl_fsm: directed-vector bench for proc_ctrl_fsm with
// hand-computed expected control outputs per instruction step.
module tb_proc_ctrl_fsm;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 2;

  logic              clk;
  logic              reset;
  logic              run;
  logic [DATA_W-1:0] din;
  logic [7:0]        ir;
  logic [7:0]        r_in;
  logic [3:0]        bus_sel;
  logic              a_in;
  logic              g_in;
  logic              add_sub;
  logic              mem_adv;
  logic              busy;
  logic              done;
`ifdef PROC_CTRL_PERF_EN
  logic [CNT_W-1:0]  instr_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  proc_ctrl_fsm #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .din      (din),
    .ir       (ir),
    .r_in     (r_in),
    .bus_sel  (bus_sel),
    .a_in     (a_in),
    .g_in     (g_in),
    .add_sub  (add_sub),
    .mem_adv  (mem_adv),
    .busy     (busy),
    .done     (done)
`ifdef PROC_CTRL_PERF_EN
    ,
    .instr_cnt(instr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Compare the full control-output set for the current step.
  task automatic check_ctrl(input string tag, input logic [7:0] e_r_in, input logic [3:0] e_bus,
                            input logic e_a, input logic e_g, input logic e_mem,
                            input logic e_busy, input logic e_done);
    check({tag, ".r_in"},    r_in,    e_r_in);
    check({tag, ".bus_sel"}, bus_sel, e_bus);
    check({tag, ".a_in"},    a_in,    e_a);
    check({tag, ".g_in"},    g_in,    e_g);
    check({tag, ".mem_adv"}, mem_adv, e_mem);
    check({tag, ".busy"},    busy,    e_busy);
    check({tag, ".done"},    done,    e_done);
  endtask

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    din   = '0;
    #2;
    check_ctrl("rst", 8'h00, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst.ir", ir, 8'h00);
    next_cycle();
    next_cycle();
    reset = 1'b0;

    // 1: idle with run low for 5 cycles
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      #1;
      check_ctrl("idle", 8'h00, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("idle.ir", ir, 8'h00);
    end
    $display("txn idle: 5 cycles run=0");

    // 2: mvi R1, #5C
    run = 1'b1; din = 8'h4A; #1;
    check_ctrl("mvi.fetch", 8'h00, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    next_cycle();
    run = 1'b0; din = 8'h5C; #1;
    check("mvi.ir", ir, 8'h4A);
    check_ctrl("mvi.t1", 8'h02, 4'h8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    next_cycle();
    #1;
    check_ctrl("mvi.end", 8'h00, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("txn mvi R1,#5C");

    // 3: mv R1 <- R3, two cycles total
    run = 1'b1; din = 8'h0B; #1;
    check_ctrl("mv.fetch", 8'h00, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    next_cycle();
    run = 1'b0; #1;
    check("mv.ir", ir, 8'h0B);
    check_ctrl("mv.t1", 8'h02, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    next_cycle();
    #1;
    check("mv.end.busy", busy, 1'b0);
`ifdef PROC_CTRL_PERF_EN
    check("mv.cnt", instr_cnt, 2'd2);
`endif
    $display("txn mv R1,R3");

    // 4: add R1, R0
    run = 1'b1; din = 8'h88; #1;
    check("add.fetch.mem_adv", mem_adv, 1'b1);
    next_cycle();
    run = 1'b0; #1;
    check_ctrl("add.t1", 8'h00, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    next_cycle();
    #1;
    check_ctrl("add.t2", 8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("add.t2.add_sub", add_sub, 1'b0);
    next_cycle();
    #1;
    check_ctrl("add.t3", 8'h02, 4'h9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    next_cycle();
    #1;
    check("add.end.busy", busy, 1'b0);
`ifdef PROC_CTRL_PERF_EN
    check("add.cnt", instr_cnt, 2'd3);
`endif
    $display("txn add R1,R0");

    // 5: sub R7, R7 with run held high, then a back-to-back mv
    run = 1'b1; din = 8'hFF; #1;
    check("sub.fetch.mem_adv", mem_adv, 1'b1);
    next_cycle();
    din = 8'h00; #1;
    check_ctrl("sub.t1", 8'h00, 4'h7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    next_cycle();
    #1;
    check_ctrl("sub.t2", 8'h00, 4'h7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("sub.t2.add_sub", add_sub, 1'b1);
    next_cycle();
    din = 8'h0B; #1;
    check_ctrl("sub.t3", 8'h80, 4'h9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    next_cycle();
    #1;
    check_ctrl("b2b.fetch", 8'h00, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef PROC_CTRL_PERF_EN
    check("sub.cnt.wrap", instr_cnt, 2'd0);
`endif
    next_cycle();
    run = 1'b0; #1;
    check("b2b.ir", ir, 8'h0B);
    check_ctrl("b2b.t1", 8'h02, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    next_cycle();
    #1;
    check("b2b.end.busy", busy, 1'b0);
`ifdef PROC_CTRL_PERF_EN
    check("b2b.cnt", instr_cnt, 2'd1);
`endif
    $display("txn sub R7,R7 then back-to-back mv R1,R3");

    // 6: reset in the middle of add (S_T2)
    run = 1'b1; din = 8'h88; #1;
    next_cycle();
    run = 1'b0; #1;
    next_cycle();
    #1;
    check("abort.t2.g_in", g_in, 1'b1);
    reset = 1'b1; #1;
    check_ctrl("abort.rst", 8'h00, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("abort.rst.ir", ir, 8'h00);
    check("abort.rst.add_sub", add_sub, 1'b0);
`ifdef PROC_CTRL_PERF_EN
    check("abort.rst.cnt", instr_cnt, 2'd0);
`endif
    next_cycle();
    check("abort.hold.done", done, 1'b0);
    reset = 1'b0;
    next_cycle();
    #1;
    check_ctrl("abort.after", 8'h00, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("txn reset during add S_T2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
